mod3_serial_scheduler: RTL and testbench

MOD3_SERIAL_SCHEDULER -- requirements
Module: mod3_serial_scheduler

---
 rtl/mod3_pkg.sv | 30 +++
 rtl/mod3_step.sv | 24 ++
 rtl/mod3_serial_scheduler.sv | 114 +++++++++++
 tb/tb_mod3_serial_scheduler.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/mod3_pkg.sv
// Shared definitions for the serial mod-3 scheduler: FSM states, widths and
// the remainder recurrence r' = (2r + b) mod 3.
package mod3_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int REM_W = 2;
    localparam int N_REQ = 2;

    function automatic logic [REM_W-1:0] mod3_next(input logic [REM_W-1:0] r,
                                                   input logic b);
        logic [REM_W-1:0] nxt;
        nxt = 2'd0;
        case ({r, b})
            3'b00_0: nxt = 2'd0;
            3'b00_1: nxt = 2'd1;
            3'b01_0: nxt = 2'd2;
            3'b01_1: nxt = 2'd0;
            3'b10_0: nxt = 2'd1;
            3'b10_1: nxt = 2'd2;
            default: nxt = 2'd0;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mod3_step.sv
// One-bit-per-cycle remainder stage: folds the next MSB into a running
// remainder modulo 3.
module mod3_step
    import mod3_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    input  logic             bit_in,
    output logic [REM_W-1:0] rem
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem <= '0;
        end else if (clear) begin
            rem <= '0;
        end else if (en) begin
            rem <= mod3_next(rem, bit_in);
        end
    end

endmodule

// File: rtl/mod3_serial_scheduler.sv
// Two-requester round-robin scheduler feeding a bit-serial divisible-by-3 test.
// Optional output rem (final remainder) is enabled by defining MOD3_REMAINDER_EN.
module mod3_serial_scheduler
    import mod3_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic [WIDTH-1:0] word0,
    input  logic [WIDTH-1:0] word1,
    output logic [N_REQ-1:0] ack,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic             is_mult
`ifdef MOD3_REMAINDER_EN
    ,
    output logic [REM_W-1:0] rem
`endif
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] cnt;
    logic             last;
    logic             grant;
    logic             capture;
    logic [REM_W-1:0] r;

    // On a tie the requester not served last wins; a lone requester always wins.
    always_comb begin
        grant = 1'b0;
        if (req == 2'b11) begin
            grant = ~last;
        end else begin
            grant = ~req[0];
        end
    end

    assign capture = (state == IDLE) && (req != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            last    <= 1'b1;
            ack     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            done_id <= 1'b0;
        end else begin
            ack     <= '0;
            done    <= 1'b0;
            done_id <= 1'b0;
            case (state)
                IDLE: begin
                    if (capture) begin
                        state <= SHIFT;
                        cnt   <= CNT_LOAD;
                        last  <= grant;
                        ack   <= grant ? 2'b10 : 2'b01;
                        busy  <= 1'b1;
                    end
                end
                SHIFT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        done_id <= last;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Operand datapath carries no reset; it is reloaded on every capture.
    always_ff @(posedge clk) begin
        if (capture) begin
            shreg <= grant ? word1 : word0;
        end else if (state == SHIFT) begin
            shreg <= {shreg[WIDTH-2:0], 1'b0};
        end
    end

    mod3_step u_step (
        .clk    (clk),
        .reset  (reset),
        .clear  (capture),
        .en     (state == SHIFT),
        .bit_in (shreg[WIDTH-1]),
        .rem    (r)
    );

    assign is_mult = done && (r == '0);

`ifdef MOD3_REMAINDER_EN
    assign rem = done ? r : '0;
`endif

endmodule

// File: tb/tb_mod3_serial_scheduler.sv
// Directed bench for mod3_serial_scheduler (WIDTH = 8); rem is checked when
// MOD3_REMAINDER_EN is defined.
module tb_mod3_serial_scheduler;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       req;
    logic [WIDTH-1:0] word0;
    logic [WIDTH-1:0] word1;
    logic [1:0]       ack;
    logic             busy;
    logic             done;
    logic             done_id;
    logic             is_mult;
`ifdef MOD3_REMAINDER_EN
    logic [1:0]       rem;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mod3_serial_scheduler #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .word0   (word0),
        .word1   (word1),
        .ack     (ack),
        .busy    (busy),
        .done    (done),
        .done_id (done_id),
        .is_mult (is_mult)
`ifdef MOD3_REMAINDER_EN
        ,
        .rem     (rem)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Capture edge, WIDTH-1 further SHIFT cycles, DONE cycle, then one IDLE cycle.
    task automatic run_one(input string tag, input logic [1:0] r,
                           input logic [WIDTH-1:0] w0, input logic [WIDTH-1:0] w1,
                           input logic id, input logic mult, input logic [1:0] rm);
        req   = r;
        word0 = w0;
        word1 = w1;
        step();
        chk({tag, ":ack"}, ack, id ? 2'b10 : 2'b01);
        chk({tag, ":busy"}, busy, 1'b1);
        chk({tag, ":done_early"}, done, 1'b0);
        for (int i = 1; i < WIDTH; i++) begin
            step();
            chk({tag, ":shift{ack,done,busy}"}, {ack, done, busy}, 4'b0001);
        end
        step();
        chk({tag, ":done"}, done, 1'b1);
        chk({tag, ":done_id"}, done_id, id);
        chk({tag, ":is_mult"}, is_mult, mult);
`ifdef MOD3_REMAINDER_EN
        chk({tag, ":rem"}, rem, rm);
`endif
        step();
        chk({tag, ":idle{ack,done,busy}"}, {ack, done, busy}, 4'b0000);
    endtask

    initial begin
        reset = 1'b0;
        req   = 2'b00;
        word0 = '0;
        word1 = '0;
        step();
        step();
        chk("reset_outputs", {ack, busy, done, done_id, is_mult}, 6'b0);
`ifdef MOD3_REMAINDER_EN
        chk("reset_rem", rem, 2'b0);
`endif
        reset = 1'b1;
        step();
        chk("idle_no_req", {ack, busy, done}, 4'b0);

        run_one("s29", 2'b01, 8'h1E, 8'h00, 1'b0, 1'b1, 2'd0);
        run_one("s30", 2'b10, 8'h00, 8'h07, 1'b1, 1'b0, 2'd1);

        run_one("s31a", 2'b11, 8'hFF, 8'h05, 1'b0, 1'b1, 2'd0);
        run_one("s31b", 2'b11, 8'hFF, 8'h05, 1'b1, 1'b0, 2'd2);
        run_one("s31c", 2'b11, 8'hFF, 8'h05, 1'b0, 1'b1, 2'd0);

        // Zero operand while req wiggles during SHIFT: no further acks.
        req   = 2'b01;
        word0 = 8'h00;
        word1 = 8'h00;
        step();
        chk("s32:ack", ack, 2'b01);
        for (int i = 1; i < WIDTH; i++) begin
            req = 2'(i);
            step();
            chk("s32:shift{ack,done,busy}", {ack, done, busy}, 4'b0001);
        end
        req = 2'b00;
        step();
        chk("s32:done", done, 1'b1);
        chk("s32:is_mult", is_mult, 1'b1);
`ifdef MOD3_REMAINDER_EN
        chk("s32:rem", rem, 2'd0);
`endif
        step();
        step();
        chk("s32:idle{ack,done,busy}", {ack, done, busy}, 4'b0000);

        // Reset pulse in the 4th SHIFT cycle aborts the operation.
        req   = 2'b01;
        word0 = 8'h55;
        step();
        req = 2'b00;
        step();
        step();
        step();
        chk("s33:pre_busy", busy, 1'b1);
        reset = 1'b0;
        #2;
        chk("s33:async_reset", {ack, busy, done, done_id, is_mult}, 6'b0);
        step();
        chk("s33:in_reset", {ack, busy, done, done_id, is_mult}, 6'b0);
        reset = 1'b1;
        for (int i = 0; i < WIDTH + 3; i++) begin
            step();
            chk("s33:no_done{ack,done,busy}", {ack, done, busy}, 4'b0000);
        end
        run_one("s33_after", 2'b01, 8'h03, 8'h00, 1'b0, 1'b1, 2'd0);

        // First tie after reset goes to requester 0.
        req   = 2'b00;
        reset = 1'b0;
        step();
        reset = 1'b1;
        run_one("tie_after_reset", 2'b11, 8'h09, 8'h04, 1'b0, 1'b1, 2'd0);
        req = 2'b00;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
